cv32e40p_lce_controller: RTL and testbench
==========================================

// Module: cv32e40p_lce_controller
// PURPOSE
//  Sequences the basic-block length checker (cv32e40p_lce_detector) from core retire events.
//  Decrements on every retired instruction and reloads at every basic-block end.
//  On detector alarm: raises an IRQ, counts alarms and waits for software acknowledge.
//  Sits between the retire stage / CSR write port and the interrupt controller.
// PARAMETERS
//  MAX_BB_LEN      32  max instructions per basic block; passed through to the detector
//  ALARM_CNT_W     8   width of the saturating alarm counter
//  ESC_THRESHOLD   4   alarm count that triggers escalation (CV32E40P_LCE_ESCALATE_EN only)
// PORTS
//  clk              in   1            clock
//  rst_n            in   1            reset, asynchronous, active-low
//  cfg_we_i         in   1            config write strobe
//  cfg_wdata_i      in   2            bit0 enable, bit1 clear alarm count (self-clearing)
//  instr_retire_i   in   1            one instruction retired this cycle
//  bb_end_i         in   1            retired instr ends a basic block (branch/jump/trap); valid only with retire
//  debug_mode_i     in   1            core in debug mode: checking paused
//  irq_ack_i        in   1            software acknowledge of pending alarm
//  irq_o            out  1            alarm interrupt request
//  alarm_count_o    out  ALARM_CNT_W  number of alarms since reset/clear, saturating
//  state_o          out  2            FSM state: 00 DISABLED, 01 ARMED, 10 ALARM, 11 LOCKED
//  halt_req_o       out  1            halt request to the core (escalation)
// BEHAVIOUR
//  Reset: state DISABLED, alarm_count 0, irq_o 0, halt_req_o 0; detector reset via the same rst_n.
//  Detector drive is combinational from state and inputs: init (reload), decrement (saturates at 0).
//  Detector alarm is combinational from its counter: 1 cycle after the decrement that reaches 0.
//  DISABLED: init=1 every cycle. cfg write with bit0=1 -> ARMED next cycle.
//  ARMED:
//   - retire & bb_end -> init; retire & !bb_end -> decrement; init wins over decrement.
//   - debug_mode_i=1 -> neither init nor decrement (counter frozen).
//   - detector alarm=1 -> ALARM; takes priority over a bb_end in the same cycle.
//  ALARM: irq_o=1 (decoded from state register); no init, no decrement (counter held at 0).
//   - alarm_count increments once, on the ARMED->ALARM transition; saturates at all-ones.
//   - irq_ack_i=1 -> init asserted that cycle, ARMED next cycle.
//  Timing: Nth decrement (N=MAX_BB_LEN) at cycle t -> alarm at t+1 -> irq_o=1 at t+2.
//  cfg write with bit0=0: from DISABLED/ARMED/ALARM -> DISABLED next cycle; beats ack and alarm.
//  cfg bit1=1: alarm_count <= 0; overrides a simultaneous increment.
//  irq_ack_i outside ALARM: ignored. Reset mid-operation: all state returns to reset values at once.
// CONFIGURATION
//  CV32E40P_LCE_ESCALATE_EN defined:
//   - ARMED->ALARM with post-increment alarm_count >= ESC_THRESHOLD -> LOCKED instead of ALARM.
//   - LOCKED: irq_o=1, halt_req_o=1, detector frozen; cfg writes and irq_ack_i ignored.
//   - Only rst_n leaves LOCKED.
//  Not defined: LOCKED unreachable (treated as DISABLED if ever decoded); halt_req_o tied 0;
//   port list unchanged.
// STRUCTURE
//  Package cv32e40p_lce_pkg: lce_state_e enum (2-bit, encodings above), cfg bit-index constants.
//  One sub-module: cv32e40p_lce_detector, instantiated with MAX_BB_LEN and driven by this FSM.
//  FSM, alarm counter and cfg decode live here; no other hierarchy.
// TESTING (MAX_BB_LEN=4, ESC_THRESHOLD=2)
//  1 Enable, 4 retires without bb_end -> alarm 1 cycle after 4th; irq_o=1 2 cycles after; alarm_count=1.
//  2 Enable, 3 retires, bb_end retire, 3 retires -> no irq; state_o stays 01.
//  3 In ALARM, pulse irq_ack_i -> irq_o=0 next cycle, state 01, counter reloaded to 4.
//  4 Retires with debug_mode_i=1 -> no decrement; alarm only after 4 non-debug retires.
//  5 Alarm cycle coincides with bb_end retire -> ALARM still entered; cfg write 0b00 in ALARM -> DISABLED, irq_o=0.
//  6 ESCALATE_EN: 2nd alarm -> state 11, halt_req_o=1; cfg/ack ignored; rst_n -> state 00, count 0.

Source files
------------

// File: rtl/cv32e40p_lce_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_lce_pkg
// Shared definitions for the basic-block length checker controller.
//   lce_state_e  : 2-bit controller state, encoding is visible on state_o
//   CFG_*_BIT    : bit positions inside the 2-bit configuration write word
// ----------------------------------------------------------------------------
package cv32e40p_lce_pkg;

  typedef enum logic [1:0] {
    LCE_DISABLED = 2'b00,
    LCE_ARMED    = 2'b01,
    LCE_ALARM    = 2'b10,
    LCE_LOCKED   = 2'b11
  } lce_state_e;

  localparam int CFG_EN_BIT  = 0;  // 1: arm the checker, 0: disable it
  localparam int CFG_CLR_BIT = 1;  // 1: clear the alarm counter (self-clearing)

endpackage

// File: rtl/cv32e40p_lce_detector.sv
// ----------------------------------------------------------------------------
// cv32e40p_lce_detector
// Counts down the instructions remaining in the current basic block.
//   clk, rst_n   : clock, asynchronous active-low reset (counter -> MAX_BB_LEN)
//   init_i       : reload counter to MAX_BB_LEN (wins over decrement_i)
//   decrement_i  : decrement counter, saturating at 0
//   alarm_o      : counter is 0 (combinational from the counter register)
// ----------------------------------------------------------------------------
module cv32e40p_lce_detector #(
  parameter int MAX_BB_LEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_i,
  input  logic decrement_i,
  output logic alarm_o
);

  localparam int                CNT_W  = $clog2(MAX_BB_LEN + 1);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(MAX_BB_LEN);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= RELOAD;
    end else if (init_i) begin
      cnt_reg <= RELOAD;
    end else if (decrement_i && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign alarm_o = (cnt_reg == '0);

endmodule

// File: rtl/cv32e40p_lce_controller.sv
// ----------------------------------------------------------------------------
// cv32e40p_lce_controller
// Sequences the basic-block length detector from retire events, raises an
// alarm interrupt, counts alarms and waits for a software acknowledge.
//   clk, rst_n      : clock, asynchronous active-low reset
//   cfg_we_i        : config write strobe
//   cfg_wdata_i     : bit0 enable, bit1 clear alarm count
//   instr_retire_i  : one instruction retired this cycle
//   bb_end_i        : retired instruction ends a basic block
//   debug_mode_i    : core in debug mode, detector frozen
//   irq_ack_i       : software acknowledge of the pending alarm
//   irq_o           : alarm interrupt request
//   alarm_count_o   : saturating alarm counter
//   state_o         : 00 DISABLED, 01 ARMED, 10 ALARM, 11 LOCKED
//   halt_req_o      : halt request to the core (escalation only)
// Optional feature: define CV32E40P_LCE_ESCALATE_EN to move to LOCKED (irq +
// halt, exit only by reset) once the alarm count reaches ESC_THRESHOLD.
// Without it LOCKED is unreachable, decodes as DISABLED and halt_req_o is 0.
// ----------------------------------------------------------------------------
module cv32e40p_lce_controller
  import cv32e40p_lce_pkg::*;
#(
  parameter int MAX_BB_LEN    = 32,
  parameter int ALARM_CNT_W   = 8,
  parameter int ESC_THRESHOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we_i,
  input  logic [1:0]             cfg_wdata_i,
  input  logic                   instr_retire_i,
  input  logic                   bb_end_i,
  input  logic                   debug_mode_i,
  input  logic                   irq_ack_i,
  output logic                   irq_o,
  output logic [ALARM_CNT_W-1:0] alarm_count_o,
  output logic [1:0]             state_o,
  output logic                   halt_req_o
);

`ifdef CV32E40P_LCE_ESCALATE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  lce_state_e             state_reg, state_next;
  logic [ALARM_CNT_W-1:0] alarm_count_reg, alarm_count_inc;
  logic                   det_init, det_dec, det_alarm;
  logic                   cnt_inc, esc_hit, locked;
  logic                   cfg_enable, cfg_disable, cfg_clear;

  assign cfg_enable  = cfg_we_i &  cfg_wdata_i[CFG_EN_BIT];
  assign cfg_disable = cfg_we_i & ~cfg_wdata_i[CFG_EN_BIT];
  assign cfg_clear   = cfg_we_i &  cfg_wdata_i[CFG_CLR_BIT];

  // LOCKED only has meaning when escalation is built in.
  assign locked = ESC_EN && (state_reg == LCE_LOCKED);

  assign alarm_count_inc = (&alarm_count_reg) ? alarm_count_reg : alarm_count_reg + 1'b1;
  // Escalation is judged on the count as it will be after this alarm.
  assign esc_hit = ESC_EN && (int'(alarm_count_inc) >= ESC_THRESHOLD);

  always_comb begin
    state_next = state_reg;
    det_init   = 1'b0;
    det_dec    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_reg)
      LCE_ARMED: begin
        if (cfg_disable) begin
          state_next = LCE_DISABLED;
        end else if (det_alarm) begin
          cnt_inc    = 1'b1;
          state_next = esc_hit ? LCE_LOCKED : LCE_ALARM;
        end
        // An alarm pending this cycle suppresses any reload from a bb_end.
        if (!debug_mode_i && !det_alarm && instr_retire_i) begin
          if (bb_end_i) det_init = 1'b1;
          else          det_dec  = 1'b1;
        end
      end
      LCE_ALARM: begin
        det_init = irq_ack_i;
        if (cfg_disable)    state_next = LCE_DISABLED;
        else if (irq_ack_i) state_next = LCE_ARMED;
      end
      default: begin
        // DISABLED, or LOCKED decoded as DISABLED when escalation is absent.
        if (!locked) begin
          det_init = 1'b1;
          if (cfg_enable) state_next = LCE_ARMED;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= LCE_DISABLED;
      alarm_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (cfg_clear && !locked) begin
        alarm_count_reg <= '0;
      end else if (cnt_inc) begin
        alarm_count_reg <= alarm_count_inc;
      end
    end
  end

  cv32e40p_lce_detector #(
    .MAX_BB_LEN (MAX_BB_LEN)
  ) u_detector (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_i      (det_init),
    .decrement_i (det_dec),
    .alarm_o     (det_alarm)
  );

  assign irq_o         = (state_reg == LCE_ALARM) || locked;
  assign halt_req_o    = locked;
  assign alarm_count_o = alarm_count_reg;
  assign state_o       = state_reg;

endmodule

// File: tb/tb_cv32e40p_lce_controller.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_lce_controller
// Directed scenarios with literal expectations followed by random traffic,
// all checked every cycle against a behavioural model of the checker.
// ----------------------------------------------------------------------------
module tb_cv32e40p_lce_controller;

  localparam int MAXL = 4;
  localparam int CW   = 3;
  localparam int TH   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef CV32E40P_LCE_ESCALATE_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_wdata = 2'b00;
  logic          retire = 1'b0, bb_end = 1'b0, debug = 1'b0, ack = 1'b0;
  logic          irq, halt;
  logic [CW-1:0] acnt;
  logic [1:0]    st;

  always #5 clk = ~clk;

  cv32e40p_lce_controller #(
    .MAX_BB_LEN    (MAXL),
    .ALARM_CNT_W   (CW),
    .ESC_THRESHOLD (TH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we_i       (cfg_we),
    .cfg_wdata_i    (cfg_wdata),
    .instr_retire_i (retire),
    .bb_end_i       (bb_end),
    .debug_mode_i   (debug),
    .irq_ack_i      (ack),
    .irq_o          (irq),
    .alarm_count_o  (acnt),
    .state_o        (st),
    .halt_req_o     (halt)
  );

  // Model: mode 0 off, 1 watching, 2 alarm pending, 3 locked;
  // m_left = instructions still allowed in the current basic block.
  int m_mode, m_left, m_cnt;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("state", int'(st), m_mode);
    chk("irq", int'(irq), (m_mode == 2 || m_mode == 3) ? 1 : 0);
    chk("halt", int'(halt), (m_mode == 3) ? 1 : 0);
    chk("alarm_count", int'(acnt), m_cnt);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_left = MAXL;
    m_cnt  = 0;
  endtask

  task automatic model_step(input bit we, input bit [1:0] wd, input bit r,
                            input bit b, input bit d, input bit a);
    int  nmode = m_mode, nleft = m_left, ncnt = m_cnt;
    bit  fired = (m_mode == 1) && (m_left == 0);
    bit  counted = 1'b0;
    bit  off_req = we && !wd[0];
    bit  on_req  = we && wd[0];
    bit  clr_req = we && wd[1];
    if (m_mode == 3) begin
      // locked: nothing moves until reset
    end else if (m_mode == 1) begin
      if (off_req) nmode = 0;
      else if (fired) begin
        counted = 1'b1;
        nmode = (ESC && ((m_cnt + 1 > CMAX ? CMAX : m_cnt + 1) >= TH)) ? 3 : 2;
      end
      if (!d && !fired && r) nleft = b ? MAXL : (m_left > 0 ? m_left - 1 : 0);
    end else if (m_mode == 2) begin
      if (a) nleft = MAXL;
      if (off_req) nmode = 0;
      else if (a) nmode = 1;
    end else begin
      nleft = MAXL;
      if (on_req) nmode = 1;
    end
    if (clr_req && m_mode != 3) ncnt = 0;
    else if (counted) ncnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    m_mode = nmode;
    m_left = nleft;
    m_cnt  = ncnt;
  endtask

  // Called at a falling edge: drive, advance the model, check at next falling edge.
  task automatic cyc(input bit we, input bit [1:0] wd, input bit r,
                     input bit b, input bit d, input bit a);
    cfg_we = we; cfg_wdata = wd; retire = r; bb_end = b; debug = d; ack = a;
    model_step(we, wd, r, b, d, a);
    @(negedge clk);
    check_model();
    $display("cyc we=%0b wd=%0b ret=%0b bb=%0b dbg=%0b ack=%0b -> state=%0d irq=%0b cnt=%0d",
             we, wd, r, b, d, a, st, irq, acnt);
  endtask

  task automatic idle();
    cyc(0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic ret_n(input int n, input bit d);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 1, 0, d, 0);
  endtask

  // Reset asserted between edges so its effect is visible before any clock.
  task automatic do_reset();
    cfg_we = 0; cfg_wdata = 0; retire = 0; bb_end = 0; debug = 0; ack = 0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    chk("rst_state", int'(st), 0);
    chk("rst_count", int'(acnt), 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_halt", int'(halt), 0);

    // Four plain retires -> alarm, irq two cycles after the 4th decrement.
    cyc(1, 2'b01, 0, 0, 0, 0);
    chk("t1_armed", int'(st), 1);
    ret_n(4, 0);
    chk("t1_irq_not_yet", int'(irq), 0);
    chk("t1_state_armed", int'(st), 1);
    idle();
    chk("t1_irq", int'(irq), 1);
    chk("t1_state_alarm", int'(st), 2);
    chk("t1_count", int'(acnt), 1);

    // Acknowledge reloads the counter to 4.
    cyc(0, 2'b00, 0, 0, 0, 1);
    chk("t3_irq_clear", int'(irq), 0);
    chk("t3_armed", int'(st), 1);
    ret_n(3, 0);
    idle();
    chk("t3_three_ok", int'(st), 1);

    // Alarm cycle coincides with a bb_end retire: alarm still wins.
    ret_n(1, 0);
    cyc(0, 2'b00, 1, 1, 0, 0);
    chk("t5_alarm_over_bbend", int'(st), ESC ? 3 : 2);
    chk("t5_count", int'(acnt), 2);
    cyc(1, 2'b00, 0, 0, 0, 0);
    chk("t5_disable", int'(st), ESC ? 3 : 0);
    chk("t5_irq", int'(irq), ESC ? 1 : 0);

    // bb_end in the middle of a run keeps the checker quiet.
    do_reset();
    cyc(1, 2'b01, 0, 0, 0, 0);
    ret_n(3, 0);
    cyc(0, 2'b00, 1, 1, 0, 0);
    ret_n(3, 0);
    idle();
    chk("t2_no_irq", int'(irq), 0);
    chk("t2_armed", int'(st), 1);

    // Debug-mode retires do not count.
    cyc(0, 2'b00, 1, 1, 0, 0);
    ret_n(4, 1);
    idle();
    chk("t4_debug_frozen", int'(st), 1);
    ret_n(4, 0);
    idle();
    chk("t4_alarm", int'(st), 2);
    chk("t4_count", int'(acnt), 1);
    // Clear while staying enabled.
    cyc(1, 2'b11, 0, 0, 0, 0);
    chk("clr_count", int'(acnt), 0);
    chk("clr_state", int'(st), 2);

`ifdef CV32E40P_LCE_ESCALATE_EN
    do_reset();
    cyc(1, 2'b01, 0, 0, 0, 0);
    ret_n(4, 0);
    idle();
    cyc(0, 2'b00, 0, 0, 0, 1);
    ret_n(4, 0);
    idle();
    chk("t6_locked", int'(st), 3);
    chk("t6_halt", int'(halt), 1);
    chk("t6_count", int'(acnt), 2);
    cyc(1, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 1);
    cyc(1, 2'b11, 0, 0, 0, 0);
    chk("t6_still_locked", int'(st), 3);
    chk("t6_count_kept", int'(acnt), 2);
    do_reset();
    chk("t6_rst_state", int'(st), 0);
    chk("t6_rst_count", int'(acnt), 0);
`endif

    // Random traffic against the model, with periodic asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      bit we, r, b, d, a;
      bit [1:0] wd;
      if (i % 700 == 699) do_reset();
      we    = ($urandom_range(0, 11) == 0);
      wd[0] = ($urandom_range(0, 3) != 0);
      wd[1] = ($urandom_range(0, 3) == 0);
      r     = $urandom_range(0, 1) == 1;
      b     = r && ($urandom_range(0, 5) == 0);
      d     = ($urandom_range(0, 7) == 0);
      a     = ($urandom_range(0, 5) == 0);
      cyc(we, wd, r, b, d, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
